// File: rtl/elevator_ctrl.sv
// elevator_ctrl: sequential controller for a 4-level car.
// Owns the request queue, its occupancy (tail) and the car position. Floor presses are
// buffered in a one-hot pending register and fed one at a time into the queue update
// logic, but only while the car is idle or the door is open.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   press_en   single-cycle floor-request strobe
//   press_lvl  requested level (0=A..3=D), valid with press_en
//   pos_lvl    current car level
//   door_open  high while in DOOR
//   move_up    high while moving up
//   move_down  high while moving down
//   queue      registered queue, entry i = bits 2i+1:2i, entry 0 = head
//   tail       registered queue occupancy, 0..4
//   pending    buffered presses not yet fed to the queue, one bit per level
module elevator_ctrl #(
    parameter int unsigned MOVE_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press_en,
    input  logic [1:0] press_lvl,
    output logic [1:0] pos_lvl,
    output logic       door_open,
    output logic       move_up,
    output logic       move_down,
    output logic [7:0] queue,
    output logic [2:0] tail,
    output logic [3:0] pending
);

    localparam int unsigned MaxCyc = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned CntW   = (MaxCyc < 2) ? 1 : $clog2(MaxCyc);

    typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

    state_e          state_q, state_d;
    logic [1:0]      pos_q, pos_d;
    logic            dir_up_q, dir_up_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      queue_q, queue_d;
    logic [2:0]      tail_q, tail_d;
    logic [3:0]      pending_q, pending_d;

    // Feed selection: lowest-index pending level, only at commit points.
    logic       commit;
    logic       feed_en;
    logic [1:0] feed_lvl;
    logic [3:0] feed_clr;

    always_comb begin
        commit   = (state_q == StIdle) || (state_q == StDoor);
        feed_en  = commit && (pending_q != 4'b0000);
        feed_lvl = 2'd0;
        feed_clr = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) begin
                feed_lvl = 2'(i);
            end
        end
        if (feed_en) begin
            feed_clr[feed_lvl] = 1'b1;
        end
    end

    // Queue update: insert the fed level unless it duplicates a queued entry or is the
    // current level, then drop any entry equal to the current level and compact.
    logic [7:0] next_queue_sub;
    logic [2:0] next_tail_sub;
    logic       stop_at_pos_lvl;
    logic       dup, hit, ins;
    logic [7:0] ins_queue;
    logic [2:0] ins_tail;
    logic [2:0] k;

    always_comb begin
        dup       = 1'b0;
        hit       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < tail_q) begin
                if (queue_q[2*i +: 2] == feed_lvl) dup = 1'b1;
                if (queue_q[2*i +: 2] == pos_q)    hit = 1'b1;
            end
        end
        stop_at_pos_lvl = hit || (feed_en && (feed_lvl == pos_q));
        ins = feed_en && !dup && (feed_lvl != pos_q) && (tail_q < 3'd4);

        ins_queue = queue_q;
        ins_tail  = tail_q;
        if (ins) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) == tail_q) ins_queue[2*i +: 2] = feed_lvl;
            end
            ins_tail = tail_q + 3'd1;
        end

        next_queue_sub = 8'h00;
        k              = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < ins_tail) && (ins_queue[2*i +: 2] != pos_q)) begin
                for (int j = 0; j < 4; j++) begin
                    if (3'(j) == k) next_queue_sub[2*j +: 2] = ins_queue[2*i +: 2];
                end
                k = k + 3'd1;
            end
        end
        next_tail_sub = k;
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;
        queue_d   = queue_q;
        tail_d    = tail_q;
        // A same-cycle press of the fed level survives the clear.
        pending_d = (pending_q & ~feed_clr) | (press_en ? (4'b0001 << press_lvl) : 4'b0000);

        if (commit) begin
            queue_d = next_queue_sub;
            tail_d  = next_tail_sub;
        end

        unique case (state_q)
            StIdle: begin
                if (stop_at_pos_lvl) begin
                    state_d = StDoor;
                    cnt_d   = CntW'(DOOR_CYCLES - 1);
                end else if (next_tail_sub != 3'd0) begin
                    // Head differs from pos_lvl whenever there is no stop.
                    state_d  = StMove;
                    dir_up_d = next_queue_sub[1:0] > pos_q;
                    cnt_d    = CntW'(MOVE_CYCLES - 1);
                end
            end
            StMove: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    pos_d   = dir_up_q ? pos_q + 2'd1 : pos_q - 2'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDoor: begin
                if (stop_at_pos_lvl) begin
                    cnt_d = CntW'(DOOR_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pos_q     <= 2'd0;
            dir_up_q  <= 1'b0;
            cnt_q     <= '0;
            queue_q   <= 8'h00;
            tail_q    <= 3'd0;
            pending_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
            queue_q   <= queue_d;
            tail_q    <= tail_d;
            pending_q <= pending_d;
        end
    end

    assign pos_lvl   = pos_q;
    assign door_open = (state_q == StDoor);
    assign move_up   = (state_q == StMove) && dir_up_q;
    assign move_down = (state_q == StMove) && !dir_up_q;
    assign queue     = queue_q;
    assign tail      = tail_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed, table-driven bench for elevator_ctrl with MOVE_CYCLES=4, DOOR_CYCLES=2.
// Status word compared each cycle: {pos, door, up, down, queue, tail, pending}.
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       press_en = 1'b0;
    logic [1:0] press_lvl = 2'd0;
    logic [1:0] pos_lvl;
    logic       door_open, move_up, move_down;
    logic [7:0] queue;
    logic [2:0] tail;
    logic [3:0] pending;

    int total = 0;
    int bad = 0;

    elevator_ctrl #(
        .MOVE_CYCLES(4),
        .DOOR_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .press_en (press_en),
        .press_lvl(press_lvl),
        .pos_lvl  (pos_lvl),
        .door_open(door_open),
        .move_up  (move_up),
        .move_down(move_down),
        .queue    (queue),
        .tail     (tail),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pen;
        logic [1:0]  plvl;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [20];

    function automatic logic [19:0] st(input logic [1:0] p, input logic d, input logic u,
                                       input logic dn, input logic [7:0] q,
                                       input logic [2:0] t, input logic [3:0] pd);
        return {p, d, u, dn, q, t, pd};
    endfunction

    function automatic logic [19:0] cur();
        return {pos_lvl, door_open, move_up, move_down, queue, tail, pending};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL %s: got %05h want %05h (pos,door,up,down,queue,tail,pending)",
                     name, cur(), exp);
        end
    endtask

    // Drive inputs at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic pen, input logic [1:0] lvl, input string name,
                        input logic [19:0] exp);
        @(negedge clk);
        press_en  = pen;
        press_lvl = lvl;
        @(posedge clk);
        #1;
        press_en = 1'b0;
        check(name, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_hold", st(0, 0, 0, 0, 8'h00, 0, 4'h0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Scenario 2 followed by scenario 6 (door reload at level C).
        vecs[0]  = '{1'b1, 2'd2, st(0, 0, 0, 0, 8'h00, 0, 4'h4)};
        for (int i = 1; i <= 4; i++) vecs[i] = '{1'b0, 2'd0, st(0, 0, 1, 0, 8'h02, 1, 4'h0)};
        vecs[5]  = '{1'b0, 2'd0, st(1, 0, 0, 0, 8'h02, 1, 4'h0)};
        for (int i = 6; i <= 9; i++) vecs[i] = '{1'b0, 2'd0, st(1, 0, 1, 0, 8'h02, 1, 4'h0)};
        vecs[10] = '{1'b0, 2'd0, st(2, 0, 0, 0, 8'h02, 1, 4'h0)};
        vecs[11] = '{1'b0, 2'd0, st(2, 1, 0, 0, 8'h00, 0, 4'h0)};
        vecs[12] = '{1'b0, 2'd0, st(2, 1, 0, 0, 8'h00, 0, 4'h0)};
        vecs[13] = '{1'b0, 2'd0, st(2, 0, 0, 0, 8'h00, 0, 4'h0)};
        vecs[14] = '{1'b1, 2'd2, st(2, 0, 0, 0, 8'h00, 0, 4'h4)};
        vecs[15] = '{1'b0, 2'd0, st(2, 1, 0, 0, 8'h00, 0, 4'h0)};
        vecs[16] = '{1'b1, 2'd2, st(2, 1, 0, 0, 8'h00, 0, 4'h4)};
        vecs[17] = '{1'b0, 2'd0, st(2, 1, 0, 0, 8'h00, 0, 4'h0)};
        vecs[18] = '{1'b0, 2'd0, st(2, 1, 0, 0, 8'h00, 0, 4'h0)};
        vecs[19] = '{1'b0, 2'd0, st(2, 0, 0, 0, 8'h00, 0, 4'h0)};

        // Scenario 1: reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", st(0, 0, 0, 0, 8'h00, 0, 4'h0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].pen, vecs[i].plvl, $sformatf("vec%0d", i), vecs[i].exp);
        end

        // Scenario 3: press current level while idle at A.
        do_reset();
        step(1'b1, 2'd0, "s3_pend", st(0, 0, 0, 0, 8'h00, 0, 4'h1));
        step(1'b0, 2'd0, "s3_door0", st(0, 1, 0, 0, 8'h00, 0, 4'h0));
        step(1'b0, 2'd0, "s3_door1", st(0, 1, 0, 0, 8'h00, 0, 4'h0));
        step(1'b0, 2'd0, "s3_idle", st(0, 0, 0, 0, 8'h00, 0, 4'h0));

        // Scenario 4: press D then B; B served in passing.
        step(1'b1, 2'd3, "s4_pendD", st(0, 0, 0, 0, 8'h00, 0, 4'h8));
        step(1'b1, 2'd1, "s4_moveA", st(0, 0, 1, 0, 8'h03, 1, 4'h2));
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, "s4_moveA", st(0, 0, 1, 0, 8'h03, 1, 4'h2));
        step(1'b0, 2'd0, "s4_atB", st(1, 0, 0, 0, 8'h03, 1, 4'h2));
        step(1'b0, 2'd0, "s4_doorB", st(1, 1, 0, 0, 8'h03, 1, 4'h0));
        step(1'b0, 2'd0, "s4_doorB1", st(1, 1, 0, 0, 8'h03, 1, 4'h0));
        step(1'b0, 2'd0, "s4_idleB", st(1, 0, 0, 0, 8'h03, 1, 4'h0));
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, "s4_moveB", st(1, 0, 1, 0, 8'h03, 1, 4'h0));
        step(1'b0, 2'd0, "s4_atC", st(2, 0, 0, 0, 8'h03, 1, 4'h0));
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, "s4_moveC", st(2, 0, 1, 0, 8'h03, 1, 4'h0));
        step(1'b0, 2'd0, "s4_atD", st(3, 0, 0, 0, 8'h03, 1, 4'h0));
        step(1'b0, 2'd0, "s4_doorD", st(3, 1, 0, 0, 8'h00, 0, 4'h0));
        step(1'b0, 2'd0, "s4_doorD1", st(3, 1, 0, 0, 8'h00, 0, 4'h0));
        step(1'b0, 2'd0, "s4_idleD", st(3, 0, 0, 0, 8'h00, 0, 4'h0));

        // Going down from D: press A, then async reset mid-MOVE.
        step(1'b1, 2'd0, "dn_pend", st(3, 0, 0, 0, 8'h00, 0, 4'h1));
        step(1'b0, 2'd0, "dn_move", st(3, 0, 0, 1, 8'h00, 1, 4'h0));
        step(1'b0, 2'd0, "dn_move1", st(3, 0, 0, 1, 8'h00, 1, 4'h0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", st(0, 0, 0, 0, 8'h00, 0, 4'h0));
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 5: presses during MOVE are held until the next commit point.
        step(1'b1, 2'd2, "s5_pendC", st(0, 0, 0, 0, 8'h00, 0, 4'h4));
        step(1'b0, 2'd0, "s5_move", st(0, 0, 1, 0, 8'h02, 1, 4'h0));
        step(1'b1, 2'd3, "s5_pD", st(0, 0, 1, 0, 8'h02, 1, 4'h8));
        step(1'b1, 2'd3, "s5_pD2", st(0, 0, 1, 0, 8'h02, 1, 4'h8));
        step(1'b1, 2'd1, "s5_pB", st(0, 0, 1, 0, 8'h02, 1, 4'hA));
        step(1'b0, 2'd0, "s5_atB", st(1, 0, 0, 0, 8'h02, 1, 4'hA));
        step(1'b0, 2'd0, "s5_feedB", st(1, 1, 0, 0, 8'h02, 1, 4'h8));
        step(1'b0, 2'd0, "s5_feedD", st(1, 1, 0, 0, 8'h0E, 2, 4'h0));
        step(1'b0, 2'd0, "s5_idle", st(1, 0, 0, 0, 8'h0E, 2, 4'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, want finish before 100000 ns");
        $fatal(1);
    end

endmodule
